// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Parametrised LED pattern generator. A clock divider produces a one-cycle
//   tick every DIV = CLK_HZ / TICK_HZ cycles. On each tick the pattern
//   advances in one of four modes: binary up, binary down, Gray up, or a
//   bouncing single-LED scanner.
//
//   Optional feature macro: LED_DIM_EN
//     When defined, a 4-bit duty input and a free-running 4-bit PWM counter
//     gate the LED outputs. The tick and the pattern state are not affected.
//
// Ports
//   clk    in   system clock; all logic on posedge
//   rst_n  in   asynchronous active-low reset
//   en     in   count enable; 0 freezes the divider and the pattern
//   mode   in   0 up, 1 down, 2 Gray, 3 scanner
//   duty   in   (LED_DIM_EN only) PWM duty, 0 = off, 15 = 15/16
//   tick   out  one-cycle strobe when the divider wraps
//   leds   out  registered LED drive, active-high
module led_pattern_gen #(
    parameter int WIDTH   = 8,
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef LED_DIM_EN
    input  logic [3:0]       duty,
`endif
    output logic             tick,
    output logic [WIDTH-1:0] leds
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam int PW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        M_UP   = 2'd0,
        M_DOWN = 2'd1,
        M_GRAY = 2'd2,
        M_SCAN = 2'd3
    } mode_e;

    mode_e            mode_q, mode_nxt;
    logic [DW-1:0]    div_q, div_nxt;
    logic             tick_nxt;
    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic [PW-1:0]    pos_q, pos_nxt;
    logic             dir_q, dir_nxt;   // 0 = moving up, 1 = moving down
    logic [WIDTH-1:0] pattern;
    logic             wrap;

    assign wrap = en && (div_q == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_UP;
            div_q  <= '0;
            tick   <= 1'b0;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            div_q  <= div_nxt;
            tick   <= tick_nxt;
            cnt_q  <= cnt_nxt;
            pos_q  <= pos_nxt;
            dir_q  <= dir_nxt;
        end
    end

    // Next-state: a mode change always wins over a coincident wrap, so the
    // seed is loaded and the divider restarts instead of advancing.
    always_comb begin
        mode_nxt = mode_q;
        div_nxt  = div_q;
        tick_nxt = 1'b0;
        cnt_nxt  = cnt_q;
        pos_nxt  = pos_q;
        dir_nxt  = dir_q;
        if (mode_e'(mode) != mode_q) begin
            mode_nxt = mode_e'(mode);
            div_nxt  = '0;
            case (mode_e'(mode))
                M_DOWN:  cnt_nxt = '1;
                M_SCAN: begin
                    pos_nxt = '0;
                    dir_nxt = 1'b0;
                end
                default: cnt_nxt = '0;
            endcase
        end else if (wrap) begin
            div_nxt  = '0;
            tick_nxt = 1'b1;
            case (mode_q)
                M_DOWN:  cnt_nxt = cnt_q - 1'b1;
                M_SCAN: begin
                    // Flip direction on arrival at an end so the end LED is
                    // shown for exactly one tick.
                    if (!dir_q) begin
                        pos_nxt = pos_q + 1'b1;
                        if (pos_q == PW'(WIDTH - 2)) dir_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos_q - 1'b1;
                        if (pos_q == PW'(1)) dir_nxt = 1'b0;
                    end
                end
                default: cnt_nxt = cnt_q + 1'b1;
            endcase
        end else if (en) begin
            div_nxt = div_q + 1'b1;
        end
    end

    // Pattern is derived from next state so leds change on the tick edge.
    always_comb begin
        pattern = '0;
        case (mode_nxt)
            M_GRAY:  pattern = cnt_nxt ^ (cnt_nxt >> 1);
            M_SCAN:  pattern[pos_nxt] = 1'b1;
            default: pattern = cnt_nxt;
        endcase
    end

`ifdef LED_DIM_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
            leds  <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
            leds  <= pattern & {WIDTH{pwm_q < duty}};
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) leds <= '0;
        else        leds <= pattern;
    end
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Scoreboard bench for led_pattern_gen with WIDTH=4, DIV=4. Stimulus pushes
//   the expected leds value for each upcoming tick; a monitor pops and
//   compares whenever tick is seen. Seeds, pause, reset and tick timing are
//   checked directly by the stimulus process.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] leds;
`ifdef LED_DIM_EN
    logic [3:0] duty = 4'd15;
`endif

    led_pattern_gen #(.WIDTH(4), .CLK_HZ(8), .TICK_HZ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
`ifdef LED_DIM_EN
        .duty  (duty),
`endif
        .tick  (tick),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every observed tick must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL tick_unexpected: got tick with leds %0d, expected no tick at %0t",
                         leds, $time);
            end else begin
                chk("tick_leds", int'(leds), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    // Run k tick periods from a tick-aligned point, then confirm the
    // scoreboard drained.
    task automatic run_ticks(input int k, input string nm);
        repeat (4 * k) @(posedge clk);
        @(negedge clk);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    // Change mode; the seed must appear on the next cycle with no tick.
    task automatic load_mode(input logic [1:0] m, input int seed, input string nm);
        mode = m;
        @(posedge clk);
        @(negedge clk);
        chk(nm, int'(leds), seed);
        chk({nm, "_tick"}, int'(tick), 0);
    endtask

    // Count posedges until tick is seen; -1 on timeout.
    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (tick !== 1'b1 && n < lim);
        if (tick !== 1'b1) n = -1;
        #1;
    endtask

    logic [3:0] gray_exp [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    logic [3:0] scan_exp [8] = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2, 4'd4};

    initial begin
        int n;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_leds", int'(leds), 0);
        chk("reset_tick", int'(tick), 0);

        // Binary up through a full wrap plus one.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 16; i++) push(4'(i));
        push(4'd1);
        rst_n = 1'b1;
        en    = 1'b1;
        run_ticks(17, "up_drain");

        // Reset mid-count: immediate clear, divider restarts from zero.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_leds", int'(leds), 0);
        chk("midrst_tick", int'(tick), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(4'd1);
        wait_tick(20, n);
        chk("midrst_first_tick", n, 4);

        // Binary down with wrap through zero.
        load_mode(2'd1, 15, "down_seed");
        for (int k = 1; k <= 16; k++) push(4'(15 - k));
        run_ticks(16, "down_drain");

        // Gray code.
        load_mode(2'd2, 0, "gray_seed");
        for (int k = 0; k < 8; k++) push(gray_exp[k]);
        run_ticks(8, "gray_drain");

        // Scanner bounce.
        load_mode(2'd3, 1, "scan_seed");
        for (int k = 0; k < 8; k++) push(scan_exp[k]);
        run_ticks(8, "scan_drain");

        // Pause for 10 cycles with the divider at 2.
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pause_leds", int'(leds), 4);
        chk("pause_tick", int'(tick), 0);
        en = 1'b1;
        push(4'd8);
        wait_tick(20, n);
        chk("pause_resume_gap", n, 2);

        // Mode change exactly when the divider sits at DIV-1.
        repeat (3) @(posedge clk);
        #1;
        load_mode(2'd0, 0, "collide_seed");
        push(4'd1);
        wait_tick(20, n);
        chk("collide_next_tick", n, 4);

        chk("final_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
